// File: rtl/barrel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : barrel_pkg
// Brief    : Shared types and helpers for the multimode element barrel unit.
// Revision : 1.0 - initial release
// ============================================================================
package barrel_pkg;

  typedef enum logic [1:0] {
    ROT  = 2'd0,
    ZERO = 2'd1,
    FILL = 2'd2,
    EDGE = 2'd3
  } mode_t;

  localparam int DEF_NUM_ELEMS  = 32;
  localparam int DEF_DATA_WIDTH = 8;

  // Element vector at the default geometry; instances use their own widths.
  typedef logic [DEF_NUM_ELEMS-1:0][DEF_DATA_WIDTH-1:0] elem_vec_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_stage.sv
`default_nettype none
// ============================================================================
// Module   : barrel_stage
// Brief    : One log stage: conditional move by 2^STAGE elements with
//            direction and wrap/fill select; registered when
//            BARREL_STAGE_REG_EN is defined, combinational otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int NUM_ELEMS  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ROT_WIDTH  = 5,
  parameter int STAGE      = 0
) (
`ifdef BARREL_STAGE_REG_EN
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 adv_i,
`endif
  input  logic                                 valid_i,
  input  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] data_i,
  input  logic [ROT_WIDTH-1:0]                 amt_i,
  input  logic                                 dir_i,
  input  logic                                 wrap_i,
  input  logic [DATA_WIDTH-1:0]                fill_i,
  output logic                                 valid_o,
  output logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] data_o,
  output logic [ROT_WIDTH-1:0]                 amt_o,
  output logic                                 dir_o,
  output logic                                 wrap_o,
  output logic [DATA_WIDTH-1:0]                fill_o
);

  localparam int SHIFT = 1 << STAGE;

  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] data_d;

  // Source indices are fixed per element; only the wrap/fill choice is dynamic.
  for (genvar j = 0; j < NUM_ELEMS; j++) begin : g_elem
    localparam bit LO_OK  = (j >= SHIFT);
    localparam int LO_SRC = LO_OK ? j - SHIFT : j - SHIFT + NUM_ELEMS;
    localparam bit HI_OK  = (j + SHIFT < NUM_ELEMS);
    localparam int HI_SRC = HI_OK ? j + SHIFT : j + SHIFT - NUM_ELEMS;

    logic [DATA_WIDTH-1:0] lo_pick;
    logic [DATA_WIDTH-1:0] hi_pick;

    assign lo_pick   = (LO_OK || wrap_i) ? data_i[LO_SRC] : fill_i;
    assign hi_pick   = (HI_OK || wrap_i) ? data_i[HI_SRC] : fill_i;
    assign data_d[j] = !amt_i[STAGE] ? data_i[j] : (dir_i ? hi_pick : lo_pick);
  end

`ifdef BARREL_STAGE_REG_EN
  logic                                 valid_q;
  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] data_q;
  logic [ROT_WIDTH-1:0]                 amt_q;
  logic                                 dir_q;
  logic                                 wrap_q;
  logic [DATA_WIDTH-1:0]                fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      fill_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      amt_q   <= amt_i;
      dir_q   <= dir_i;
      wrap_q  <= wrap_i;
      fill_q  <= fill_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign dir_o   = dir_q;
  assign wrap_o  = wrap_q;
  assign fill_o  = fill_q;
`else
  assign valid_o = valid_i;
  assign data_o  = data_d;
  assign amt_o   = amt_i;
  assign dir_o   = dir_i;
  assign wrap_o  = wrap_i;
  assign fill_o  = fill_i;
`endif

endmodule
`default_nettype wire

// File: rtl/barrel_multimode.sv
`default_nettype none
// ============================================================================
// Module   : barrel_multimode
// Brief    : Element barrel rotator/shifter with ROT/ZERO/FILL/EDGE modes,
//            start/rdy input and valid/ack output handshakes. Defining
//            BARREL_STAGE_REG_EN registers every log stage (latency ROT_WIDTH).
// Revision : 1.0 - initial release
// ============================================================================
module barrel_multimode
  import barrel_pkg::*;
#(
  parameter int NUM_ELEMS  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ROT_WIDTH  = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] ip,
  input  logic [ROT_WIDTH-1:0]                 rot,
  input  logic                                 dir,
  input  logic [1:0]                           mode,
  input  logic [DATA_WIDTH-1:0]                fill,
  input  logic                                 start,
  output logic                                 rdy,
  output logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] op,
  output logic                                 valid,
  input  logic                                 ack
);

  if (NUM_ELEMS < 2) begin : g_chk_elems
    $error("barrel_multimode: NUM_ELEMS must be >= 2");
  end
  if (ROT_WIDTH != clog2(NUM_ELEMS)) begin : g_chk_rot_width
    $error("barrel_multimode: ROT_WIDTH must equal clog2(NUM_ELEMS)");
  end

  localparam logic [ROT_WIDTH:0] ELEMS_EXT = (ROT_WIDTH + 1)'(NUM_ELEMS);

  mode_t                                mode_s;
  logic                                 adv;
  logic                                 is_rot;
  logic                                 over;
  logic [ROT_WIDTH-1:0]                 rot_wrapped;
  logic [DATA_WIDTH-1:0]                fill_sel;
  logic [ROT_WIDTH-1:0]                 amt_in;
  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] data_in;

  assign mode_s      = mode_t'(mode);
  assign is_rot      = (mode_s == ROT);
  assign over        = ({1'b0, rot} >= ELEMS_EXT);
  assign rot_wrapped = rot - ELEMS_EXT[ROT_WIDTH-1:0];

  always_comb begin
    fill_sel = '0;
    case (mode_s)
      FILL:    fill_sel = fill;
      EDGE:    fill_sel = dir ? ip[NUM_ELEMS-1] : ip[0];
      default: fill_sel = '0;
    endcase
  end

  // Out-of-range amounts: rotation folds once, shifts flush the whole vector.
  always_comb begin
    amt_in  = rot;
    data_in = ip;
    if (over) begin
      if (is_rot) begin
        amt_in = rot_wrapped;
      end else begin
        amt_in  = '0;
        data_in = {NUM_ELEMS{fill_sel}};
      end
    end
  end

  logic                                 valid_s [ROT_WIDTH+1];
  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] data_s  [ROT_WIDTH+1];
  logic [ROT_WIDTH-1:0]                 amt_s   [ROT_WIDTH+1];
  logic                                 dir_s   [ROT_WIDTH+1];
  logic                                 wrap_s  [ROT_WIDTH+1];
  logic [DATA_WIDTH-1:0]                fill_s  [ROT_WIDTH+1];

  assign valid_s[0] = start;
  assign data_s[0]  = data_in;
  assign amt_s[0]   = amt_in;
  assign dir_s[0]   = dir;
  assign wrap_s[0]  = is_rot;
  assign fill_s[0]  = fill_sel;

  for (genvar k = 0; k < ROT_WIDTH; k++) begin : g_stage
    barrel_stage #(
      .NUM_ELEMS  (NUM_ELEMS),
      .DATA_WIDTH (DATA_WIDTH),
      .ROT_WIDTH  (ROT_WIDTH),
      .STAGE      (k)
    ) u_stage (
`ifdef BARREL_STAGE_REG_EN
      .clk     (clk),
      .rst     (rst),
      .adv_i   (adv),
`endif
      .valid_i (valid_s[k]),
      .data_i  (data_s[k]),
      .amt_i   (amt_s[k]),
      .dir_i   (dir_s[k]),
      .wrap_i  (wrap_s[k]),
      .fill_i  (fill_s[k]),
      .valid_o (valid_s[k+1]),
      .data_o  (data_s[k+1]),
      .amt_o   (amt_s[k+1]),
      .dir_o   (dir_s[k+1]),
      .wrap_o  (wrap_s[k+1]),
      .fill_o  (fill_s[k+1])
    );
  end

`ifdef BARREL_STAGE_REG_EN
  assign valid = valid_s[ROT_WIDTH];
  assign op    = data_s[ROT_WIDTH];
`else
  logic                                 valid_q;
  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
    end else if (adv) begin
      valid_q <= valid_s[ROT_WIDTH];
      if (valid_s[ROT_WIDTH]) begin
        op_q <= data_s[ROT_WIDTH];
      end
    end
  end

  assign valid = valid_q;
  assign op    = op_q;
`endif

  assign adv = !valid || ack;
  assign rdy = adv;

endmodule
`default_nettype wire

// File: tb/tb_barrel_multimode.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_multimode
// Brief    : Directed self-checking bench for barrel_multimode (32 and 24 elements).
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_multimode;

  localparam int N   = 32;
  localparam int N24 = 24;
  localparam int W   = 8;
  localparam int RW  = 5;
`ifdef BARREL_STAGE_REG_EN
  localparam int L = RW;
`else
  localparam int L = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, dir, start, ack;
  logic [RW-1:0]     rot;
  logic [1:0]        mode;
  logic [W-1:0]      fill;
  logic [N-1:0][W-1:0]   ip, op;
  logic [N24-1:0][W-1:0] ip24, op24;
  logic              rdy, valid, rdy24, valid24;
  int                tests = 0;
  int                fails = 0;

  always #5 clk = ~clk;

  barrel_multimode #(.NUM_ELEMS(N), .DATA_WIDTH(W), .ROT_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .ip(ip), .rot(rot), .dir(dir), .mode(mode), .fill(fill),
    .start(start), .rdy(rdy), .op(op), .valid(valid), .ack(ack)
  );

  barrel_multimode #(.NUM_ELEMS(N24), .DATA_WIDTH(W), .ROT_WIDTH(RW)) dut24 (
    .clk(clk), .rst(rst), .ip(ip24), .rot(rot), .dir(dir), .mode(mode), .fill(fill),
    .start(start), .rdy(rdy24), .op(op24), .valid(valid24), .ack(ack)
  );

  // One-cycle start pulse, then wait (bounded) for valid; returns cycles seen.
  task automatic xact(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0; rot = '0; dir = 1'b0; mode = 2'd0; fill = '0;
    repeat (2) @(negedge clk);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (op !== '0) begin fails++; $display("FAIL reset_op: got %h want 0", op); end
    tests++; if (valid24 !== 1'b0) begin fails++; $display("FAIL reset_valid24: got %b want 0", valid24); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    tests++; if (rdy24 !== 1'b1) begin fails++; $display("FAIL reset_rdy24: got %b want 1", rdy24); end
  endtask

  task automatic test_rot_left();
    int lat;
    mode = 2'd0; dir = 1'b0; rot = 5'd11;
    xact(lat);
    tests++; if (lat !== L) begin fails++; $display("FAIL rot_latency: got %0d want %0d", lat, L); end
    tests++; if (op[0] !== 8'd21) begin fails++; $display("FAIL rot_op0: got %0d want 21", op[0]); end
    tests++; if (op[10] !== 8'd31) begin fails++; $display("FAIL rot_op10: got %0d want 31", op[10]); end
    tests++; if (op[11] !== 8'd0) begin fails++; $display("FAIL rot_op11: got %0d want 0", op[11]); end
    tests++; if (op[31] !== 8'd20) begin fails++; $display("FAIL rot_op31: got %0d want 20", op[31]); end
    retire();
  endtask

  task automatic test_shift_modes();
    int lat;
    mode = 2'd1; dir = 1'b1; rot = 5'd3;
    xact(lat);
    tests++; if (op[0] !== 8'd3) begin fails++; $display("FAIL zero_op0: got %0d want 3", op[0]); end
    tests++; if (op[28] !== 8'd31) begin fails++; $display("FAIL zero_op28: got %0d want 31", op[28]); end
    for (int i = 29; i < 32; i++) begin
      tests++; if (op[i] !== 8'd0) begin fails++; $display("FAIL zero_op%0d: got %0d want 0", i, op[i]); end
    end
    retire();
    mode = 2'd3;
    xact(lat);
    for (int i = 29; i < 32; i++) begin
      tests++; if (op[i] !== 8'd31) begin fails++; $display("FAIL edge_op%0d: got %0d want 31", i, op[i]); end
    end
    retire();
    mode = 2'd2; dir = 1'b0; rot = 5'd31; fill = 8'hAA;
    xact(lat);
    tests++; if (op[30] !== 8'hAA) begin fails++; $display("FAIL fill_op30: got %h want aa", op[30]); end
    tests++; if (op[31] !== 8'd0) begin fails++; $display("FAIL fill_op31: got %h want 00", op[31]); end
    retire();
  endtask

  task automatic test_rot_zero();
    int lat;
    logic [N-1:0][W-1:0] exp_v;
    for (int i = 0; i < N; i++) exp_v[i] = 8'(i);
    mode = 2'd3; dir = 1'b1; rot = 5'd0;
    xact(lat);
    tests++; if (op !== exp_v) begin fails++; $display("FAIL rot0_identity: got %h want %h", op, exp_v); end
    retire();
  endtask

  task automatic test_n24();
    int lat;
    logic [N24-1:0][W-1:0] exp_v;
    for (int i = 0; i < N24; i++) exp_v[i] = 8'hAA;
    mode = 2'd0; dir = 1'b0; rot = 5'd30;
    xact(lat);
    tests++; if (op24[6] !== 8'd0) begin fails++; $display("FAIL n24_op6: got %0d want 0", op24[6]); end
    tests++; if (op24[0] !== 8'd18) begin fails++; $display("FAIL n24_op0: got %0d want 18", op24[0]); end
    tests++; if (op24[23] !== 8'd17) begin fails++; $display("FAIL n24_op23: got %0d want 17", op24[23]); end
    retire();
    mode = 2'd2; fill = 8'hAA;
    xact(lat);
    tests++; if (op24 !== exp_v) begin fails++; $display("FAIL n24_fill_all: got %h want %h", op24, exp_v); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    mode = 2'd0; dir = 1'b0; rot = 5'd1;
    xact(lat);
    start = 1'b1; rot = 5'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL bp_valid_c%0d: got %b want 1", c, valid); end
      tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL bp_rdy_c%0d: got %b want 0", c, rdy); end
      tests++; if (op[0] !== 8'd31) begin fails++; $display("FAIL bp_op_c%0d: got %0d want 31", c, op[0]); end
      @(negedge clk);
    end
    ack = 1'b1;
    #1;
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL bp_rdy_on_ack: got %b want 1", rdy); end
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
    lat = 1;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++; if (lat !== L) begin fails++; $display("FAIL bp_accept_latency: got %0d want %0d", lat, L); end
    tests++; if (op[0] !== 8'd30) begin fails++; $display("FAIL bp_new_op0: got %0d want 30", op[0]); end
    retire();
  endtask

  task automatic test_back_to_back();
    int got   = 0;
    int first = -1;
    bit gap   = 1'b0;
    mode = 2'd0; dir = 1'b0; ack = 1'b1;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      if (valid) begin
        if (first < 0) first = c;
        if (c != first + got) gap = 1'b1;
        if (got < 8) begin
          tests++;
          if (op[0] !== 8'((N - got) % N)) begin
            fails++; $display("FAIL stream_item%0d: got %0d want %0d", got, op[0], (N - got) % N);
          end
        end
        got++;
      end
      if (c < 8) begin start = 1'b1; rot = 5'(c); end
      else start = 1'b0;
    end
    ack = 1'b0;
    tests++; if (got !== 8) begin fails++; $display("FAIL stream_count: got %0d want 8", got); end
    tests++; if (gap !== 1'b0) begin fails++; $display("FAIL stream_gaps: got %b want 0", gap); end
  endtask

  task automatic test_reset_flush();
    bit stale = 1'b0;
    mode = 2'd0; dir = 1'b0; rot = 5'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", valid); end
    tests++; if (op !== '0) begin fails++; $display("FAIL flush_op: got %h want 0", op); end
    tests++; if (valid24 !== 1'b0) begin fails++; $display("FAIL flush_valid24: got %b want 0", valid24); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid) stale = 1'b1;
    end
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL flush_stale: got %b want 0", stale); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) ip[i] = 8'(i);
    for (int i = 0; i < N24; i++) ip24[i] = 8'(i);
    test_reset();
    test_rot_left();
    test_shift_modes();
    test_rot_zero();
    test_n24();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
